// File: rtl/seg7_scan_decoder_pkg.sv
// Shared constants for active-low seven-segment display monitors.
// Segment codes match the encoder: bit0=a ... bit6=g, a lit segment reads 0.
package seg7_scan_decoder_pkg;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h18;

   localparam logic [3:0] BCD_INVALID = 4'hF;

   // ST_ prefix keeps the state names clear of the SETTLE parameter
   typedef enum logic [1:0] {
      ST_WAIT_AN  = 2'd0,
      ST_SETTLE   = 2'd1,
      ST_CAPTURE  = 2'd2,
      ST_HOLD     = 2'd3
   } cap_state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of an active-low segment pattern back to BCD.
// Unknown patterns give BCD_INVALID with the invalid flag raised.
module seg7_to_bcd
   import seg7_scan_decoder_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] bcd_o,
   output logic       invalid_o
);

   always_comb begin
      bcd_o     = BCD_INVALID;
      invalid_o = 1'b0;
      case (seg_i)
         SEG_0:   bcd_o = 4'd0;
         SEG_1:   bcd_o = 4'd1;
         SEG_2:   bcd_o = 4'd2;
         SEG_3:   bcd_o = 4'd3;
         SEG_4:   bcd_o = 4'd4;
         SEG_5:   bcd_o = 4'd5;
         SEG_6:   bcd_o = 4'd6;
         SEG_7:   bcd_o = 4'd7;
         SEG_8:   bcd_o = 4'd8;
         SEG_9:   bcd_o = 4'd9;
         default: invalid_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed active-low 7-segment bus, recovers each digit once its
// anode has settled, and publishes a frame after MATCH identical frames.
module seg7_scan_decoder
   import seg7_scan_decoder_pkg::*;
#(
   parameter int NDIG   = 4,
   parameter int SETTLE = 3,
   parameter int MATCH  = 2
) (
   input  logic                iClk,
   input  logic                iRst,
   input  logic [6:0]          iSeg,
   input  logic [NDIG-1:0]     iAn,
   output logic [4*NDIG-1:0]   oBCD,
   output logic                oValid,
   output logic                oErr,
   input  logic                iErrClr
);

   localparam int          IW       = $clog2(NDIG);
   localparam logic [3:0]  SETTLE_L = 4'(SETTLE);
   localparam logic [2:0]  MATCH_L  = 3'(MATCH);

   cap_state_e           state_q;
   logic [3:0]           cnt_q;
   logic [IW-1:0]        cur_q;
   logic [NDIG-1:0]      an_q;
   logic [4*NDIG-1:0]    shadow_q;
   logic [4*NDIG-1:0]    prev_q;
   logic [NDIG-1:0]      mask_q;
   logic [2:0]           match_q;
   logic [2:0]           match_d;
   logic                 publish_d;

   logic [3:0]           dec_bcd;
   logic                 dec_inv;
   logic [IW-1:0]        an_idx;
   logic                 an_onehot;
   logic                 an_multi;
   logic                 frame_end;
   logic                 frame_bad;
   logic                 err_set;

   seg7_to_bcd u_dec (
      .seg_i     (iSeg),
      .bcd_o     (dec_bcd),
      .invalid_o (dec_inv)
   );

   always_comb begin
      int unsigned n_low;
      n_low  = 0;
      an_idx = '0;
      for (int unsigned k = 0; k < NDIG; k++) begin
         if (!iAn[k]) begin
            n_low++;
            an_idx = IW'(k);
         end
      end
      an_onehot = (n_low == 1);
      an_multi  = (n_low > 1);
   end

   assign err_set   = an_multi || (state_q == ST_CAPTURE && dec_inv);
   assign frame_end = &mask_q;

   // A frame holding any invalid digit restarts the match count from zero
   always_comb begin
      frame_bad = 1'b0;
      for (int unsigned k = 0; k < NDIG; k++) begin
         if (shadow_q[4*k +: 4] == BCD_INVALID) frame_bad = 1'b1;
      end
      match_d   = match_q;
      publish_d = 1'b0;
      if (frame_bad) begin
         match_d = 3'd0;
      end else if (shadow_q == prev_q) begin
         if (match_q < MATCH_L) begin
            match_d   = match_q + 3'd1;
            publish_d = (match_q + 3'd1 == MATCH_L);
         end
      end else begin
         match_d   = 3'd1;
         publish_d = (MATCH_L == 3'd1);
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q  <= ST_WAIT_AN;
         cnt_q    <= '0;
         cur_q    <= '0;
         an_q     <= '1;
         shadow_q <= '0;
         prev_q   <= '0;
         mask_q   <= '0;
         match_q  <= '0;
         oBCD     <= '0;
         oValid   <= 1'b0;
         oErr     <= 1'b0;
      end else begin
         oValid <= 1'b0;
         if (err_set)      oErr <= 1'b1;
         else if (iErrClr) oErr <= 1'b0;

         if (frame_end) begin
            prev_q  <= shadow_q;
            mask_q  <= '0;
            match_q <= match_d;
            if (publish_d) begin
               oBCD   <= shadow_q;
               oValid <= 1'b1;
            end
         end

         if (an_multi) begin
            state_q <= ST_WAIT_AN;
         end else begin
            unique case (state_q)
               ST_WAIT_AN: if (an_onehot) begin
                  cur_q   <= an_idx;
                  an_q    <= iAn;
                  cnt_q   <= 4'd1;
                  state_q <= (SETTLE <= 1) ? ST_CAPTURE : ST_SETTLE;
               end
               ST_SETTLE: begin
                  if (iAn != an_q) begin
                     state_q <= ST_WAIT_AN;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                     if (cnt_q + 4'd1 >= SETTLE_L) state_q <= ST_CAPTURE;
                  end
               end
               ST_CAPTURE: begin
                  shadow_q[{cur_q, 2'b00} +: 4] <= dec_bcd;
                  mask_q[cur_q]                 <= 1'b1;
                  state_q                       <= ST_HOLD;
               end
               ST_HOLD: if (iAn != an_q) state_q <= ST_WAIT_AN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: decode table vectors plus scan-timing
// sequences for settle glitches, bad codes, multi-hot anodes and reset.
module tb_seg7_scan_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [15:0] bcd;
   logic        valid;
   logic        err;
   logic        errclr;

   int nvec    = 0;
   int nbad    = 0;
   int npulse  = 0;
   int last_pos = -1;
   int cur_pos  = 99;

   typedef struct {
      logic [27:0] segs;
      logic [15:0] exp_bcd;
      int          exp_pulses;
      logic        exp_err;
   } vec_t;

   vec_t tbl [7];

   seg7_scan_decoder #(.NDIG(4), .SETTLE(3), .MATCH(2)) dut (
      .iClk    (clk),
      .iRst    (rst),
      .iSeg    (seg),
      .iAn     (an),
      .oBCD    (bcd),
      .oValid  (valid),
      .oErr    (err),
      .iErrClr (errclr)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h18;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic logic [27:0] segs_of(input logic [15:0] v);
      logic [27:0] s;
      for (int unsigned k = 0; k < 4; k++) s[7*k +: 7] = seg_of(v[4*k +: 4]);
      return s;
   endfunction

   function automatic logic [27:0] segs_with(input logic [15:0] v, input int unsigned k,
                                             input logic [6:0] code);
      logic [27:0] s;
      s = segs_of(v);
      s[7*k +: 7] = code;
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (valid) begin
         npulse++;
         last_pos = cur_pos;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic scan_digit(input int unsigned k, input logic [6:0] s, input int unsigned cycles);
      an  = ~(4'b0001 << k);
      seg = s;
      for (int unsigned i = 0; i < cycles; i++) begin
         cur_pos = int'(k * 8 + i);
         tick();
      end
      cur_pos = 99;
   endtask

   task automatic scan_segs(input logic [27:0] s);
      for (int unsigned k = 0; k < 4; k++) scan_digit(k, s[7*k +: 7], 8);
   endtask

   task automatic clear_err();
      errclr = 1'b1;
      tick();
      errclr = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{segs_of(16'h9876),              16'h9876, 1, 1'b0};
      tbl[1] = '{segs_of(16'h5432),              16'h5432, 1, 1'b0};
      tbl[2] = '{segs_of(16'h1098),              16'h1098, 1, 1'b0};
      tbl[3] = '{segs_with(16'h1098, 1, 7'h41),  16'h1098, 0, 1'b1};
      tbl[4] = '{segs_of(16'h0000),              16'h0000, 1, 1'b0};
      tbl[5] = '{segs_with(16'h4321, 0, 7'h01),  16'h0000, 0, 1'b1};
      tbl[6] = '{segs_of(16'h4321),              16'h4321, 1, 1'b0};

      rst = 1'b1; an = '1; seg = 7'h7F; errclr = 1'b0;
      repeat (3) tick();
      check("reset_bcd", bcd, 16'h0000);
      check("reset_valid", valid, 1'b0);
      check("reset_err", err, 1'b0);
      rst = 1'b0;
      tick();

      // Display 1234: publish exactly once, two cycles after the last capture
      npulse = 0;
      scan_segs(segs_of(16'h1234));
      check("t2_frame1_pulses", npulse, 0);
      scan_segs(segs_of(16'h1234));
      check("t2_frame2_pulses", npulse, 1);
      check("t2_latency_pos", last_pos, 3 * 8 + 5);
      check("t2_bcd", bcd, 16'h1234);
      scan_segs(segs_of(16'h1234));
      check("t2_frame3_pulses", npulse, 1);

      // Short anode on digit 3 is skipped; frame completes on the next scan
      npulse = 0;
      scan_digit(0, seg_of(4'd8), 8);
      scan_digit(1, seg_of(4'd7), 8);
      scan_digit(2, seg_of(4'd6), 8);
      scan_digit(3, seg_of(4'd5), 2);
      scan_segs(segs_of(16'h5678));
      check("t3_no_early_pulse", npulse, 0);
      scan_segs(segs_of(16'h5678));
      check("t3_pulses", npulse, 1);
      check("t3_pos", last_pos, 3 * 8 + 5);
      check("t3_bcd", bcd, 16'h5678);

      // Invalid code on digit 2
      npulse = 0;
      scan_segs(segs_with(16'h1234, 2, 7'h7F));
      check("t4_err_set", err, 1'b1);
      scan_segs(segs_with(16'h1234, 2, 7'h7F));
      check("t4_no_pulse", npulse, 0);
      check("t4_bcd_held", bcd, 16'h5678);
      clear_err();
      check("t4_err_cleared", err, 1'b0);
      scan_segs(segs_of(16'h1234));
      scan_segs(segs_of(16'h1234));
      check("t4_pulses_after_clear", npulse, 1);
      check("t4_bcd", bcd, 16'h1234);
      check("t4_err_stays_clear", err, 1'b0);

      // Two anodes low mid-scan
      npulse = 0;
      scan_digit(0, seg_of(4'd8), 8);
      scan_digit(1, seg_of(4'd7), 8);
      an = 4'b0101; seg = seg_of(4'd0);
      repeat (3) tick();
      check("t5_err_multi", err, 1'b1);
      scan_digit(2, seg_of(4'd6), 8);
      scan_digit(3, seg_of(4'd5), 8);
      check("t5_no_pulse_first", npulse, 0);
      scan_segs(segs_of(16'h5678));
      check("t5_pulses", npulse, 1);
      check("t5_bcd", bcd, 16'h5678);
      clear_err();
      check("t5_err_cleared", err, 1'b0);

      // 1234 -> 1239, then alternating frames never publish
      npulse = 0;
      scan_segs(segs_of(16'h1234));
      scan_segs(segs_of(16'h1234));
      check("t6_pub_1234", npulse, 1);
      scan_segs(segs_of(16'h1239));
      check("t6_1239_first", npulse, 1);
      scan_segs(segs_of(16'h1239));
      check("t6_pub_1239", npulse, 2);
      check("t6_bcd", bcd, 16'h1239);
      for (int unsigned r = 0; r < 2; r++) begin
         scan_segs(segs_of(16'h1234));
         scan_segs(segs_of(16'h1239));
      end
      check("t6_alternating", npulse, 2);
      check("t6_bcd_held", bcd, 16'h1239);

      // Decode table vectors, two identical frames each
      for (int unsigned i = 0; i < 7; i++) begin
         npulse = 0;
         scan_segs(tbl[i].segs);
         scan_segs(tbl[i].segs);
         check($sformatf("tbl%0d_pulses", i), npulse, tbl[i].exp_pulses);
         check($sformatf("tbl%0d_bcd", i), bcd, tbl[i].exp_bcd);
         check($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
         if (tbl[i].exp_err) clear_err();
      end

      // Reset mid-scan discards partial data
      npulse = 0;
      scan_digit(0, seg_of(4'd8), 8);
      scan_digit(1, seg_of(4'd7), 8);
      an = 4'b0011;
      tick();
      check("t1_err_before_reset", err, 1'b1);
      rst = 1'b1; an = '1;
      repeat (3) tick();
      check("t1_bcd", bcd, 16'h0000);
      check("t1_valid", valid, 1'b0);
      check("t1_err", err, 1'b0);
      rst = 1'b0;
      scan_digit(2, seg_of(4'd2), 8);
      scan_digit(3, seg_of(4'd1), 8);
      scan_segs(segs_of(16'h1234));
      check("t1_no_pulse", npulse, 0);
      scan_segs(segs_of(16'h1234));
      check("t1_pulses", npulse, 1);
      check("t1_pos", last_pos, 1 * 8 + 5);
      check("t1_bcd_after", bcd, 16'h1234);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
